pdm_audio_out: RTL
==================

// Module: pdm_audio_out
// PURPOSE
//  Playback counterpart of the microphone capture path: accepts signed PCM samples on a valid/ready
//  handshake and drives a 1-bit PDM stream to the PWM audio amplifier (ampPWM/ampSD pins).
//  First-order sigma-delta modulator clocked by an internal bit-clock enable derived from clk.
//  One-entry holding buffer between the sample source (FIFO/decimator side) and the modulator.
// PARAMETERS
//  SAMPLE_W  16  PCM sample width, two's complement
//  CLK_DIV   50  clk cycles per PDM bit; even, >=2 (100 MHz / 50 = 2 MHz bit rate)
//  OSR       64  PDM bits per PCM sample; >=2
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-low reset
//  enable       in   1         1 = play; 0 = stop at next sample boundary
//  s_data       in   SAMPLE_W  PCM sample, signed
//  s_valid      in   1         s_data valid
//  s_ready      out  1         holding register empty; transfer when s_valid & s_ready
//  mclk         out  1         PDM bit clock, 50% duty, period CLK_DIV clk cycles
//  ampPWM       out  1         PDM data to amplifier
//  ampSD        out  1         amplifier enable (1 = on)
//  sample_tick  out  1         1-cycle pulse when a new sample enters the modulator
//  underrun     out  1         sticky: sample boundary reached with holding register empty
//  underrun_clr in   1         synchronous clear of underrun (set wins if same cycle)
//  busy         out  1         1 while FSM in RUN
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0 except s_ready=1 from first clk edge after release;
//   accumulator, counters, buffer cleared; FSM=IDLE. Reset mid-RUN forces ampSD=ampPWM=0 at once.
//  Bit tick: div_cnt counts 0..CLK_DIV-1 in RUN (held 0 in IDLE); tick when div_cnt==CLK_DIV-1.
//   mclk=1 for div_cnt<CLK_DIV/2, else 0; mclk=0 in IDLE.
//  Sample period: bit_cnt 0..OSR-1 advances on tick; boundary = tick with bit_cnt==OSR-1.
//  Holding register: s_ready = ~hold_valid (registered). Accept sets hold_valid next cycle;
//   consumption clears it next cycle; no accept possible in the consume cycle (s_ready=0).
//  Modulator: u = s_data ^ (1<<(SAMPLE_W-1)) (offset binary). On each tick:
//   {c,acc} = acc + u (SAMPLE_W+1 bits); ampPWM <= c. Output density = u/2^SAMPLE_W.
//  FSM:
//   IDLE: ampSD=0, ampPWM=0, busy=0. If enable & hold_valid: load cur<=hold, pulse sample_tick,
//    clear acc, -> RUN (first tick CLK_DIV cycles later).
//   RUN: ampSD=1, busy=1. At boundary: enable=0 -> IDLE (ampSD falls next cycle, buffer kept);
//    else hold_valid -> load cur, pulse sample_tick; else load midscale (0), set underrun, stay RUN.
//   enable dropping mid-period has no effect until boundary.
//  acc not cleared between samples in RUN (continuous noise shaping).
// CONFIGURATION
//  PDM_DITHER_EN defined: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset,
//   steps every tick in RUN; u[0] is replaced by u[0]^lfsr[0] before the add (breaks idle tones).
//  PDM_DITHER_EN undefined: no LFSR logic; modulator exactly as above (bit-exact reference).
// TESTING (CLK_DIV=4, OSR=8, SAMPLE_W=16, PDM_DITHER_EN undefined unless stated)
//  1 reset=0 mid-run for 3 cycles -> ampSD/ampPWM/mclk/busy/underrun=0 immediately; s_ready=1 after release.
//  2 stream 8 samples 0x0000 back-to-back, enable=1 -> 64 ticks with exactly 32 ampPWM ones (alternating).
//  3 sample 0x7FFF x8 -> >=63 ones in 64 ticks; sample 0x8000 x8 -> 0 ones; sample_tick every 32 clk.
//  4 send 1 sample then stop s_valid -> at boundary underrun=1, ampSD stays 1, 50% density; underrun_clr -> 0.
//  5 enable=0 at bit 3 of a period -> remaining 4 ticks output, then IDLE, ampSD=0, hold kept, s_ready=0.
//  6 PDM_DITHER_EN defined, 0x0000 x16 -> ones count 64+-4 over 128 ticks; LFSR sequence matches model.

Source files
------------

// File: rtl/pdm_audio_out.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_audio_out
//  Purpose  : Accepts signed PCM samples on a valid/ready handshake, holds one
//             sample in a single-entry buffer and plays it as a 1-bit PDM
//             stream through a first-order sigma-delta modulator. The bit rate
//             is an enable derived from clk (CLK_DIV clk cycles per PDM bit),
//             with OSR PDM bits per PCM sample.
//  Options  : define PDM_DITHER_EN to add 16-bit LFSR dither on the LSB of the
//             modulator input.
//  Revision : 1.0 - initial release
// ============================================================================
module pdm_audio_out #(
  parameter int SAMPLE_W = 16,
  parameter int CLK_DIV  = 50,
  parameter int OSR      = 64
) (
  input  logic                clk,
  input  logic                reset,         // asynchronous, active low
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                mclk,
  output logic                ampPWM,
  output logic                ampSD,
  output logic                sample_tick,
  output logic                underrun,
  input  logic                underrun_clr,
  output logic                busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);

  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(OSR - 1);
  localparam logic [SAMPLE_W-1:0] SIGN_FLIP = {1'b1, {(SAMPLE_W-1){1'b0}}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] hold;
  logic                hold_valid;
  logic                hold_valid_next;
  logic [SAMPLE_W-1:0] cur;
  logic [SAMPLE_W-1:0] acc;
  logic                pwm;

  logic                running;
  logic                tick;
  logic                boundary;
  logic                start;
  logic                load_hold;
  logic                starve;
  logic                accept;
  logic [SAMPLE_W-1:0] pcm_u;
  logic [SAMPLE_W-1:0] mod_in;
  logic [SAMPLE_W:0]   acc_sum;

  // Sequencing events shared by the FSM and the datapath
  assign running   = (state == ST_RUN);
  assign tick      = running && (div_cnt == DIV_LAST);
  assign boundary  = tick && (bit_cnt == BIT_LAST);
  assign start     = (state == ST_IDLE) && enable && hold_valid;
  assign load_hold = start || (boundary && enable && hold_valid);
  assign starve    = boundary && enable && !hold_valid;
  assign accept    = s_valid && s_ready;

  // Consumption and acceptance can never coincide: accept needs an empty buffer
  assign hold_valid_next = load_hold ? 1'b0 : (accept ? 1'b1 : hold_valid);

  // Offset-binary view of the current sample feeds the modulator
  assign pcm_u = cur ^ SIGN_FLIP;

`ifdef PDM_DITHER_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced once per PDM bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 16'hACE1;
    end else if (tick) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign mod_in = {pcm_u[SAMPLE_W-1:1], pcm_u[0] ^ lfsr[0]};
`else
  assign mod_in = pcm_u;
`endif

  assign acc_sum = {1'b0, acc} + {1'b0, mod_in};

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: start on a buffered sample, stop only at a sample boundary
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (boundary && !enable) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: amplifier gating, busy flag and bit clock
  always_comb begin
    ampSD  = running;
    busy   = running;
    mclk   = running && (div_cnt < DIV_HALF);
    ampPWM = running && pwm;
  end

  // Bit-clock divider and bit-within-sample counter, both parked at 0 in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (!running) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
      end
    end
  end

  // One-entry holding buffer between the sample source and the modulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      hold_valid <= hold_valid_next;
      if (accept) begin
        hold <= s_data;
      end
    end
  end

  // Modulator: accumulator persists across samples within a run for continuous shaping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= '0;
      acc <= '0;
      pwm <= 1'b0;
    end else begin
      if (load_hold) begin
        cur <= hold;
      end else if (starve) begin
        cur <= '0;                    // midscale when the source falls behind
      end
      if (start) begin
        acc <= '0;
        pwm <= 1'b0;
      end else if (tick) begin
        acc <= acc_sum[SAMPLE_W-1:0];
        pwm <= acc_sum[SAMPLE_W];
      end
    end
  end

  // Status: ready mirrors the next buffer state so a full buffer is never re-accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready     <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      s_ready     <= !hold_valid_next;
      sample_tick <= load_hold;
      if (starve) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
